// File: rtl/x_multdiv_unit_if.sv
// Issue/result bundle between the decode/execute latch and the iterative multiply/divide unit.
interface x_multdiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             mult;
   logic             div;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic [4:0]       rd_in;
   logic             stall;
   logic [WIDTH-1:0] result;
   logic [4:0]       result_rd;
   logic             result_ready;
   logic             exception;

   modport master (
      output mult, div, operand_a, operand_b, rd_in,
      input  stall, result, result_rd, result_ready, exception
   );

   modport slave (
      input  mult, div, operand_a, operand_b, rd_in,
      output stall, result, result_rd, result_ready, exception
   );
endinterface

// File: rtl/x_multdiv_unit.sv
// Iterative signed shift-add multiply / restoring divide, WIDTH cycles per operation.
// Optional MULTDIV_EARLY_ZERO_EN: zero-operand ops skip RUN and complete the cycle after issue.
//
// state | meaning
// IDLE  | waiting for mult/div flag; operands latched at issue
// RUN   | one shift-add or restoring-divide iteration per cycle
// DONE  | result_ready pulse; start flags ignored
module x_multdiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               reset,
   x_multdiv_unit_if.slave    bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q;
   logic [2*WIDTH:0]     p_q;     // {partial product | remainder, multiplier | quotient}
   logic [WIDTH-1:0]     m_q;     // multiplicand or divisor magnitude
   logic                 is_div_q;
   logic                 neg_q;
   logic                 dz_q;
   logic [4:0]           rd_q;

   logic                 start;
   logic                 start_div;
   logic                 early;
   logic                 a_neg, b_neg;
   logic [WIDTH-1:0]     a_mag, b_mag;

   assign start     = bus.mult | bus.div;
   assign start_div = bus.div & ~bus.mult;
   assign a_neg     = bus.operand_a[WIDTH-1];
   assign b_neg     = bus.operand_b[WIDTH-1];
   assign a_mag     = a_neg ? -bus.operand_a : bus.operand_a;
   assign b_mag     = b_neg ? -bus.operand_b : bus.operand_b;

`ifdef MULTDIV_EARLY_ZERO_EN
   assign early = (bus.operand_a == '0) | (bus.operand_b == '0);
`else
   assign early = 1'b0;
`endif

   // iteration datapath
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH:0]     mul_next;
   logic [WIDTH:0]       rem_sh;
   logic [WIDTH:0]       rem_diff;
   logic [2*WIDTH:0]     div_next;

   always_comb begin
      mul_sum  = p_q[2*WIDTH:WIDTH] + (p_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
      mul_next = {mul_sum, p_q[WIDTH-1:0]} >> 1;
      rem_sh   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, m_q};
      if (rem_sh >= {1'b0, m_q})
         div_next = {rem_diff, p_q[WIDTH-2:0], 1'b1};
      else
         div_next = {rem_sh, p_q[WIDTH-2:0], 1'b0};
   end

   // completion values; sign applied to magnitudes only at the end
   logic [2*WIDTH-1:0]   prod_s;
   logic [WIDTH-1:0]     quo_s;
   logic [WIDTH-1:0]     fin_result;
   logic                 fin_exc;

   always_comb begin
      prod_s = neg_q ? -p_q[2*WIDTH-1:0] : p_q[2*WIDTH-1:0];
      quo_s  = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
      if (is_div_q) begin
         fin_result = dz_q ? '0 : quo_s;
         // only MIN / -1 yields a positive quotient of magnitude 2^(WIDTH-1)
         fin_exc    = dz_q | (~neg_q & p_q[WIDTH-1]);
      end else begin
         fin_result = prod_s[WIDTH-1:0];
         fin_exc    = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
      end
   end

   always_comb begin
      state_d          = state_q;
      bus.stall        = 1'b0;
      bus.result_ready = 1'b0;
      bus.result       = '0;
      bus.result_rd    = '0;
      bus.exception    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               bus.stall = 1'b1;
               state_d   = early ? DONE : RUN;
            end
         end
         RUN: begin
            bus.stall = 1'b1;
            if (cnt_q == CNT_W'(WIDTH-1))
               state_d = DONE;
         end
         DONE: begin
            bus.result_ready = 1'b1;
            bus.result       = fin_result;
            bus.result_rd    = rd_q;
            bus.exception    = fin_exc;
            state_d          = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         p_q      <= '0;
         m_q      <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         dz_q     <= 1'b0;
         rd_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  cnt_q    <= '0;
                  m_q      <= start_div ? b_mag : a_mag;
                  p_q      <= early ? '0 : {{(WIDTH+1){1'b0}}, (start_div ? a_mag : b_mag)};
                  is_div_q <= start_div;
                  neg_q    <= a_neg ^ b_neg;
                  dz_q     <= start_div & (bus.operand_b == '0);
                  rd_q     <= bus.rd_in;
               end
            end
            RUN: begin
               p_q   <= is_div_q ? div_next : mul_next;
               cnt_q <= cnt_q + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_x_multdiv_unit.sv
// Randomized and directed self-checking bench for x_multdiv_unit against a plain-arithmetic model.
module tb_x_multdiv_unit;
   logic clk = 1'b0;
   logic reset;
   int   cyc_g = 0;
   int   checks = 0;
   int   failures = 0;
   int   rdy_pulses = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc_g <= cyc_g + 1;
   always @(negedge clk) if (bus.result_ready === 1'b1) rdy_pulses <= rdy_pulses + 1;

   x_multdiv_unit_if #(.WIDTH(32)) bus ();

   x_multdiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic e);
      longint p;
      int     sa, sb;
      if (is_mult) begin
         p = longint'($signed(a)) * longint'($signed(b));
         r = p[31:0];
         e = (p != longint'($signed(p[31:0])));
      end else if (b == 32'd0) begin
         r = 32'd0;
         e = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         r = 32'h8000_0000;
         e = 1'b1;
      end else begin
         sa = a;
         sb = b;
         r  = sa / sb;
         e  = 1'b0;
      end
   endfunction

   // Called just after a rising edge with the unit idle; returns just after the edge ending DONE.
   task automatic do_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit gap,
                        output logic [31:0] r_obs, output int issue_cyc, output int rdy_cyc);
      logic [31:0] er;
      logic        ee;
      int          lat;
      int          k;
      bit          stall_ok;
      bit          quiet_ok;
      model(m, a, b, er, ee);
      lat = 33;
`ifdef MULTDIV_EARLY_ZERO_EN
      if (a == 32'd0 || b == 32'd0) lat = 1;
`endif
      stall_ok      = 1'b1;
      quiet_ok      = 1'b1;
      bus.mult      = m;
      bus.div       = d;
      bus.operand_a = a;
      bus.operand_b = b;
      bus.rd_in     = rd;
      issue_cyc     = cyc_g;
      @(negedge clk);
      chk("stall_issue", 64'(bus.stall), 64'd1);
      chk("ready_issue", 64'(bus.result_ready), 64'd0);
      k = 0;
      while (1) begin
         @(negedge clk);
         k++;
         if (bus.result_ready === 1'b1) break;
         if (bus.stall !== 1'b1) stall_ok = 1'b0;
         if (bus.result !== 32'd0 || bus.result_rd !== 5'd0 || bus.exception !== 1'b0) quiet_ok = 1'b0;
         if (k >= 100) break;
      end
      rdy_cyc = cyc_g;
      r_obs   = bus.result;
      chk("latency", 64'(k), 64'(lat));
      chk("result", 64'(bus.result), 64'(er));
      chk("result_rd", 64'(bus.result_rd), 64'(rd));
      chk("exception", 64'(bus.exception), 64'(ee));
      chk("stall_done", 64'(bus.stall), 64'd0);
      chk("stall_run", 64'(stall_ok), 64'd1);
      chk("quiet_outputs", 64'(quiet_ok), 64'd1);
      @(posedge clk);
      #1;
      bus.mult = 1'b0;
      bus.div  = 1'b0;
      if (gap) begin
         @(negedge clk);
         chk("no_restart_stall", 64'(bus.stall), 64'd0);
         chk("no_restart_ready", 64'(bus.result_ready), 64'd0);
         @(posedge clk);
         #1;
      end
   endtask

   logic [31:0] r;
   logic [31:0] ra, rb;
   int          ic1, rc1, ic2, rc2, pulses0;
   int          sel;

   function automatic logic [31:0] pick(input int s);
      logic [31:0] v;
      case (s)
         0: v = 32'd0;
         1: v = 32'h8000_0000;
         2: v = 32'hFFFF_FFFF;
         3: v = 32'($urandom_range(0, 20));
         4: v = -32'($urandom_range(1, 20));
         5: v = 32'h7FFF_FFFF;
         default: v = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      bus.mult      = 1'b0;
      bus.div       = 1'b0;
      bus.operand_a = '0;
      bus.operand_b = '0;
      bus.rd_in     = '0;
      reset         = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_stall", 64'(bus.stall), 64'd0);
      chk("rst_ready", 64'(bus.result_ready), 64'd0);
      chk("rst_result", 64'(bus.result), 64'd0);
      chk("rst_rd", 64'(bus.result_rd), 64'd0);
      chk("rst_exc", 64'(bus.exception), 64'd0);
      @(posedge clk);
      #1;

      do_op(1, 0, 32'd7, 32'hFFFF_FFFA, 5'd9, 1, r, ic1, rc1);
      chk("mul_7_m6", 64'(r), 64'hFFFF_FFD6);
      do_op(1, 0, 32'h0001_0000, 32'h0001_0000, 5'd3, 1, r, ic1, rc1);
      chk("mul_ovf", 64'(r), 64'h0);
      do_op(1, 0, 32'h7FFF_FFFF, 32'd2, 5'd4, 1, r, ic1, rc1);
      chk("mul_max2", 64'(r), 64'hFFFF_FFFE);
      do_op(0, 1, 32'hFFFF_FFF9, 32'd2, 5'd5, 1, r, ic1, rc1);
      chk("div_m7_2", 64'(r), 64'hFFFF_FFFD);
      do_op(0, 1, 32'd100, 32'hFFFF_FFF9, 5'd6, 1, r, ic1, rc1);
      chk("div_100_m7", 64'(r), 64'hFFFF_FFF2);
      do_op(0, 1, 32'd5, 32'd0, 5'd7, 1, r, ic1, rc1);
      chk("div_by_zero", 64'(r), 64'h0);
      do_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1, r, ic1, rc1);
      chk("div_min_m1", 64'(r), 64'h8000_0000);
      do_op(1, 1, 32'd10, 32'd3, 5'd10, 1, r, ic1, rc1);
      chk("mult_wins", 64'(r), 64'd30);

      // abort by reset mid-multiply
      pulses0       = rdy_pulses;
      bus.mult      = 1'b1;
      bus.operand_a = 32'd123;
      bus.operand_b = 32'd456;
      bus.rd_in     = 5'd11;
      repeat (10) @(posedge clk);
      #1;
      reset    = 1'b1;
      bus.mult = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_stall", 64'(bus.stall), 64'd0);
      chk("abort_ready", 64'(bus.result_ready), 64'd0);
      @(posedge clk);
      #1;
      chk("abort_no_pulse", 64'(rdy_pulses - pulses0), 64'd0);
      do_op(0, 1, 32'd1000, 32'd7, 5'd12, 1, r, ic1, rc1);
      chk("after_abort_div", 64'(r), 64'd142);

      // back-to-back multiplies, second flag raised in the cycle after DONE
      do_op(1, 0, 32'd3, 32'd4, 5'd13, 0, r, ic1, rc1);
      do_op(1, 0, 32'hFFFF_FFFB, 32'd6, 5'd14, 1, r, ic2, rc2);
      chk("b2b_first", 64'(rc1 - ic1), 64'd33);
      chk("b2b_second_issue", 64'(ic2 - ic1), 64'd34);
      chk("b2b_second_ready", 64'(rc2 - ic1), 64'd67);

      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 9);
         ra  = pick(sel);
         sel = $urandom_range(0, 9);
         rb  = pick(sel);
         sel = $urandom_range(0, 2);
         do_op(sel != 1, sel != 0, ra, rb, 5'($urandom_range(0, 31)), 1, r, ic1, rc1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/x_multdiv_unit.md
Name: x_multdiv_unit

Overview:
Iterative signed multiply/divide unit in the execute stage, directly downstream of the decode/execute pipeline latch.
- Consumes the latch's mult/div decode flags and the A/B operands.
- Runs a shift-add multiply or restoring divide over WIDTH cycles.
- Holds stall high while busy so the upstream latch write enables are deasserted.
- Delivers the result, destination register and exception flag for one cycle to the execute/memory latch.

Parameters:
WIDTH, 32, operand/result width in bits; iteration count equals WIDTH
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
mult  input  1  start signed multiply (decode-control flag, held by upstream while stalled)
div  input  1  start signed divide
operand_a  input  WIDTH  multiplicand / dividend
operand_b  input  WIDTH  multiplier / divisor
rd_in  input  5  destination register of the issuing instruction
stall  output  1  freeze upstream stages (drives upstream wren low)
result  output  WIDTH  product low word or quotient; valid when result_ready=1
result_rd  output  5  captured rd_in; valid when result_ready=1
result_ready  output  1  one-cycle pulse, result valid
exception  output  1  valid with result_ready: overflow, divide-by-zero or divide overflow

Behaviour:
- Interface is fixed: one clock, clk; synchronous active-high reset.
- Reset: state=IDLE. stall, result, result_rd, result_ready and exception are all 0. Internal counter and accumulators are cleared.
- A reset asserted mid-operation aborts the operation with no result pulse. The unit is in IDLE on the next cycle.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - (mult|div)=1: latch operands, op type and rd_in; counter=0; next state RUN.
  - mult and div both high: multiply wins, and div is ignored for that instruction.
  - stall is combinational: stall = (state==IDLE & (mult|div)) | (state==RUN). Upstream therefore freezes in the issue cycle.
- RUN:
  - One iteration per cycle; counter increments.
  - When counter reaches WIDTH-1, the final iteration is performed and next state is DONE.
  - mult/div inputs are ignored in RUN.
- DONE:
  - result_ready=1, stall=0, and result/result_rd/exception are driven.
  - Next state is always IDLE.
  - Start flags are ignored in DONE, because the flags still visible belong to the completing instruction.
- Latency: issue in cycle 0, RUN in cycles 1..WIDTH, result_ready in cycle WIDTH+1 (cycle 33 at default).
- stall is high in cycles 0..WIDTH.
- Back-to-back ops: the next instruction's flag, seen in IDLE at cycle WIDTH+2, starts a new operation.
- Multiply:
  - Operands are converted to magnitudes, shift-add accumulates a 2*WIDTH product, and the sign is applied at completion.
  - result = low WIDTH bits of the signed product.
  - exception=1 iff the full product is not the sign-extension of its low word.
- Divide:
  - Restoring division on magnitudes; quotient truncates toward zero; sign = sign(a) XOR sign(b). Remainder is discarded.
  - Divisor 0: result=0, exception=1.
  - Dividend = most-negative value and divisor = -1: result = most-negative value, exception=1.
  - Both special cases still take the full WIDTH-cycle latency.
- result, result_rd and exception are 0 whenever result_ready=0.

Optional Feature:
MULTDIV_EARLY_ZERO_EN
- Defined: in IDLE at issue, the unit checks for a multiply with either operand 0, or a divide with dividend 0 or divisor 0.
  - On a match it skips RUN and goes IDLE->DONE, so result_ready is in cycle 1 and stall is high only in cycle 0.
  - Values and exceptions are unchanged: products 0, quotient 0, divide-by-zero still flags exception.
- Undefined: every operation takes the full WIDTH+1 latency.

Test Plan:
- Reset, then mult=1, a=7, b=-6 (0xFFFFFFFA) at cycle 0 -> stall high cycles 0..32; cycle 33: result_ready=1, result=0xFFFFFFD6, exception=0, result_rd=rd_in.
- mult a=0x00010000, b=0x00010000 -> cycle 33: result=0x00000000, exception=1; also a=0x7FFFFFFF, b=2 -> result=0xFFFFFFFE, exception=1.
- div a=-7 (0xFFFFFFF9), b=2 -> cycle 33: result=0xFFFFFFFD (-3), exception=0; div a=100, b=-7 -> 0xFFFFFFF2 (-14).
- div a=5, b=0 -> result=0, exception=1; div a=0x80000000, b=0xFFFFFFFF -> result=0x80000000, exception=1; both at cycle 33 without feature, div-by-zero at cycle 1 with MULTDIV_EARLY_ZERO_EN.
- mult issued, reset asserted at cycle 10 -> cycle 11: stall=0, result_ready never pulses; a new div issued at cycle 12 completes at cycle 45.
- mult and div both high -> multiply performed. Two consecutive mults (second flag at cycle 34) -> two result_ready pulses at cycles 33 and 67, and no restart during DONE.
